// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer placed directly after uart_rx.
// A three-state capture FSM takes each completed byte from the receiver's
// ready/data pair. It pushes the byte into a circular FIFO, or drops it when
// the FIFO is full, and answers with a one-cycle ready_clr pulse. The read
// side is first-word-fall-through, so rd_data always shows the head entry.
//
// Optional feature macro: UART_RX_FIFO_DROP_CNT_EN
//   defined   -> 16-bit saturating drop_count of discarded bytes
//   undefined -> drop_count is tied to 16'h0000

module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  output logic             rx_ready_clr,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic [15:0]      drop_count
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             capture;
  logic             push;
  logic             pop;
  logic             drop;

  // Status flags come straight from the occupancy counter.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_data  = mem[rd_ptr];

  // A pop in the same cycle frees a slot, so a full FIFO may still accept the byte.
  assign pop  = rd_en && !empty;
  assign push = capture && (!full || rd_en);
  assign drop = capture && full && !rd_en;

  // The acknowledge is decoded from state, so it drops as soon as reset asserts.
  assign rx_ready_clr = (state == S_ACK);

  // Capture FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      // NOTE: use non-blocking assignments in clocked blocks so that every
      // register samples values from before the edge, whatever the block order.
      state <= next_state;
    end
  end

  // Capture FSM next state. WAIT holds until the receiver lowers ready,
  // so one byte is never captured twice.
  always_comb begin
    // NOTE: give every signal a default first; otherwise a path through the
    // case that skips an assignment infers a latch.
    next_state = state;
    capture    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_ready) begin
          capture    = 1'b1;
          next_state = S_ACK;
        end
      end
      S_ACK: begin
        next_state = S_WAIT;
      end
      S_WAIT: begin
        if (!rx_ready) begin
          next_state = S_IDLE;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Byte storage, written at the write pointer on each push.
  // NOTE: the storage array has no reset. Empty entries are never observable,
  // and leaving it unreset lets synthesis map it onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // Pointers wrap modulo DEPTH through their natural width.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Occupancy: a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !push) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Sticky overflow flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (overflow_clr) begin
      overflow_q <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped bytes since reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH = 16).
// A table of per-cycle vectors covers the basic capture and pop behaviour.
// Hand-written sequences then cover fill/order/wrap, overflow, push into a
// full FIFO with a simultaneous pop, and asynchronous reset during ACK.

module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef UART_RX_FIFO_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP1 = 16'd1;
`else
  localparam logic [15:0] EXP_DROP1 = 16'd0;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             rx_ready_clr;
  logic             rd_en;
  logic [7:0]       rd_data;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             overflow_clr;
  logic [15:0]      drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .rx_ready_clr (rx_ready_clr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic [7:0] data;
    logic       rd;
    logic       oclr;
    logic       e_clr;
    int         e_count;
    logic       e_empty;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive the inputs, advance one edge and sample 1 ns later.
  task automatic step(input logic rdy, input logic [7:0] data, input logic rd, input logic oclr);
    rx_ready     = rdy;
    rx_data      = data;
    rd_en        = rd;
    overflow_clr = oclr;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rdy, input logic [7:0] data, input logic rd,
                              input logic e_clr, input int e_count,
                              input logic chk, input logic [7:0] e_data);
    vec_t v;
    v.rdy = rdy; v.data = data; v.rd = rd; v.oclr = 1'b0;
    v.e_clr = e_clr; v.e_count = e_count; v.e_empty = (e_count == 0);
    v.chk_data = chk; v.e_data = e_data;
    return v;
  endfunction

  // One full byte transfer: capture with the ack checked, then WAIT -> IDLE.
  task automatic send_byte(input logic [7:0] b, input string name);
    step(1'b1, b, 1'b0, 1'b0);
    check({name, " ack"}, rx_ready_clr, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // Check the head entry, then pop it.
  task automatic pop_expect(input logic [7:0] b, input string name);
    check(name, rd_data, b);
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; rd_en = 1'b0; overflow_clr = 1'b0;
    #12;
    check("rst clr",      rx_ready_clr, 1'b0);
    check("rst count",    count, 0);
    check("rst empty",    empty, 1'b1);
    check("rst full",     full, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst drop",     drop_count, 16'h0000);
    reset_n = 1'b1;
    #1;

    // Table: single byte, held ready, then a pop while empty.
    vecs.push_back(mk(1'b1, 8'hA5, 1'b0, 1'b1, 1, 1'b1, 8'hA5));   // capture, ACK
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5));   // WAIT
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'hA5));   // IDLE
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00));   // pop -> empty
    vecs.push_back(mk(1'b1, 8'h3C, 1'b0, 1'b1, 1, 1'b1, 8'h3C));   // capture
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1'b1, 8'hC3, 1'b0, 1'b0, 1, 1'b1, 8'h3C)); // held ready: no recapture
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 8'h3C));   // WAIT -> IDLE
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00));   // pop
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00));   // pop while empty

    foreach (vecs[i]) begin
      step(vecs[i].rdy, vecs[i].data, vecs[i].rd, vecs[i].oclr);
      check($sformatf("vec%0d clr", i),   rx_ready_clr, vecs[i].e_clr);
      check($sformatf("vec%0d count", i), count, vecs[i].e_count);
      check($sformatf("vec%0d empty", i), empty, vecs[i].e_empty);
      if (vecs[i].chk_data)
        check($sformatf("vec%0d data", i), rd_data, vecs[i].e_data);
    end

    // Fill 00..0F.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), "fill");
    check("fill full",  full, 1'b1);
    check("fill count", count, 16);

    // Overflow: byte dropped, ack still sent.
    send_byte(8'hEE, "ovf");
    check("ovf flag",  overflow, 1'b1);
    check("ovf drop",  drop_count, EXP_DROP1);
    check("ovf count", count, 16);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf clr", overflow, 1'b0);

    // Full FIFO with a simultaneous pop: 5A is accepted, head 00 leaves.
    step(1'b1, 8'h5A, 1'b1, 1'b0);
    check("fullpop ack",   rx_ready_clr, 1'b1);
    check("fullpop count", count, 16);
    check("fullpop ovf",   overflow, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < DEPTH; i++) pop_expect(8'(i), "drain order");
    pop_expect(8'h5A, "drain last");
    check("drain empty", empty, 1'b1);
    check("drain count", count, 0);

    // Second pass 10..1F exercises pointer wrap.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), "wrap fill");
    check("wrap full", full, 1'b1);
    for (int i = 0; i < DEPTH; i++) pop_expect(8'(8'h10 + i), "wrap order");
    check("wrap empty", empty, 1'b1);

    // Async reset during ACK with count = 5.
    for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), "pre-rst");
    step(1'b1, 8'h44, 1'b0, 1'b0);
    check("ack count", count, 5);
    check("ack clr",   rx_ready_clr, 1'b1);
    rx_data = 8'h77;
    #2 reset_n = 1'b0;
    #1;
    check("arst clr",   rx_ready_clr, 1'b0);
    check("arst count", count, 0);
    check("arst empty", empty, 1'b1);
    check("arst full",  full, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    // rx_ready is still high: it is captured as a new byte.
    @(posedge clk);
    #1;
    check("post-rst ack",   rx_ready_clr, 1'b1);
    check("post-rst count", count, 1);
    check("post-rst data",  rd_data, 8'h77);
    rx_ready = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
